// File: rtl/fp_mul_pkg.sv
// fp_mul_pkg: shared state type, IEEE-754 single-precision field layout,
// quiet-NaN constant and out_flags bit positions for the fp_mul_seq slice.
package fp_mul_pkg;

    localparam int unsigned DATA_W_DEF   = 32;
    localparam int unsigned EXP_BIAS_DEF = 127;

    // Field layout of a 32-bit single-precision operand.
    localparam int unsigned SIGN_POS = 31;
    localparam int unsigned EXP_W    = 8;
    localparam int unsigned EXP_LSB  = 23;
    localparam int unsigned MAN_W    = 23;
    localparam int unsigned MAN_LSB  = 0;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    // out_flags = {nan, inf, zero, bypass}
    localparam int unsigned FLAGS_W     = 4;
    localparam int unsigned FLAG_NAN    = 3;
    localparam int unsigned FLAG_INF    = 2;
    localparam int unsigned FLAG_ZERO   = 1;
    localparam int unsigned FLAG_BYPASS = 0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        CALC = 3'd2,
        CAPT = 3'd3,
        HOLD = 3'd4
    } state_t;

endpackage

// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: request/response handshake plus the control and operand
// lines to the external multiplier. slave = sequencer side, master = the
// requester/consumer/multiplier side.
interface fp_mul_seq_if
    import fp_mul_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);
    logic               in_valid;
    logic               in_ready;
    logic [DATA_W-1:0]  in_a;
    logic [DATA_W-1:0]  in_b;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_result;
    logic [FLAGS_W-1:0] out_flags;
    logic               mul_load;
    logic               mul_en;
    logic [DATA_W-1:0]  mul_a;
    logic [DATA_W-1:0]  mul_b;
    logic [DATA_W-1:0]  mul_result;

    modport slave (
        input  in_valid, in_a, in_b, out_ready, mul_result,
        output in_ready, out_valid, out_result, out_flags,
               mul_load, mul_en, mul_a, mul_b
    );

    modport master (
        output in_valid, in_a, in_b, out_ready, mul_result,
        input  in_ready, out_valid, out_result, out_flags,
               mul_load, mul_en, mul_a, mul_b
    );

endinterface

// File: rtl/fp_classify.sv
// fp_classify: combinational operand classifier (zero / inf / nan / sign).
// Only built with FP_MUL_SPECIAL_EN, the sole configuration that uses it.
// Subnormals (exponent 0) are classified as zero.
`ifdef FP_MUL_SPECIAL_EN
module fp_classify
    import fp_mul_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned EXP_BIAS = EXP_BIAS_DEF
) (
    input  logic [DATA_W-1:0] op,
    output logic              is_zero,
    output logic              is_inf,
    output logic              is_nan,
    output logic              sign
);
    localparam logic [EXP_W-1:0] EXP_MAX = EXP_W'(2 * EXP_BIAS + 1);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] man_f;

    // Split the operand into fields and decode its class.
    always_comb begin
        exp_f   = op[EXP_LSB +: EXP_W];
        man_f   = op[MAN_LSB +: MAN_W];
        sign    = op[SIGN_POS];
        is_zero = (exp_f == '0);
        is_inf  = (exp_f == EXP_MAX) && (man_f == '0);
        is_nan  = (exp_f == EXP_MAX) && (man_f != '0);
    end

endmodule
`endif

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: sequencer for an external multi-cycle FP multiplier.
// IDLE accepts a request, LOAD/CALC drive the multiplier, CAPT registers its
// result, HOLD presents it until the consumer takes it.
// Optional macro FP_MUL_SPECIAL_EN: NaN/inf/zero operands bypass the
// multiplier and go IDLE->HOLD with a canned result and flags.
module fp_mul_seq
    import fp_mul_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned EXP_BIAS = EXP_BIAS_DEF
) (
    input logic         clk,
    input logic         rst,
    fp_mul_seq_if.slave bus
);
    if (DATA_W != 32 || EXP_BIAS != 127) begin : g_bad_cfg
        $error("fp_mul_seq supports IEEE-754 single precision only");
    end

    state_t            state;
    state_t            state_next;
    logic              xfer;
    logic              special;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] res_r;

`ifdef FP_MUL_SPECIAL_EN
    logic [DATA_W-1:0]  special_res;
    logic [FLAGS_W-1:0] special_flags;
    logic [FLAGS_W-1:0] flags_r;
    logic a_zero, a_inf, a_nan, a_sign;
    logic b_zero, b_inf, b_nan, b_sign;

    fp_classify #(.DATA_W(DATA_W), .EXP_BIAS(EXP_BIAS)) u_cls_a (
        .op(bus.in_a), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan), .sign(a_sign)
    );

    fp_classify #(.DATA_W(DATA_W), .EXP_BIAS(EXP_BIAS)) u_cls_b (
        .op(bus.in_b), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan), .sign(b_sign)
    );

    // Special-operand result; NaN (incl. inf*0) beats inf, inf beats zero.
    always_comb begin
        special       = 1'b0;
        special_res   = '0;
        special_flags = '0;
        if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) begin
            special                    = 1'b1;
            special_res                = DATA_W'(QNAN);
            special_flags[FLAG_NAN]    = 1'b1;
            special_flags[FLAG_BYPASS] = 1'b1;
        end else if (a_inf || b_inf) begin
            special                         = 1'b1;
            special_res[SIGN_POS]           = a_sign ^ b_sign;
            special_res[EXP_LSB +: EXP_W]   = '1;
            special_flags[FLAG_INF]         = 1'b1;
            special_flags[FLAG_BYPASS]      = 1'b1;
        end else if (a_zero || b_zero) begin
            special                    = 1'b1;
            special_res[SIGN_POS]      = a_sign ^ b_sign;
            special_flags[FLAG_ZERO]   = 1'b1;
            special_flags[FLAG_BYPASS] = 1'b1;
        end
    end

    assign bus.out_flags = flags_r;
`else
    assign special       = 1'b0;
    assign bus.out_flags = '0;
`endif

    assign xfer = bus.in_valid && (state == IDLE);

    // State register; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state plus handshake and multiplier control, all decoded from state.
    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.mul_load  = 1'b0;
        bus.mul_en    = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (xfer) begin
                    state_next = special ? HOLD : LOAD;
                end
            end
            LOAD: begin
                bus.mul_load = 1'b1;
                bus.mul_en   = 1'b1;
                state_next   = CALC;
            end
            CALC: begin
                bus.mul_en = 1'b1;
                state_next = CAPT;
            end
            CAPT: begin
                state_next = HOLD;
            end
            HOLD: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture at transfer; result capture from multiplier or bypass.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
`ifdef FP_MUL_SPECIAL_EN
            flags_r <= '0;
`endif
        end else begin
            if (xfer) begin
                a_r <= bus.in_a;
                b_r <= bus.in_b;
            end
            if (state == CAPT) begin
                res_r <= bus.mul_result;
`ifdef FP_MUL_SPECIAL_EN
                flags_r <= '0;
`endif
            end
`ifdef FP_MUL_SPECIAL_EN
            if (xfer && special) begin
                res_r   <= special_res;
                flags_r <= special_flags;
            end
`endif
        end
    end

    assign bus.mul_a      = a_r;
    assign bus.mul_b      = b_r;
    assign bus.out_result = res_r;

endmodule

// File: tb/tb_fp_mul_seq.sv
// tb_fp_mul_seq: self-checking bench for fp_mul_seq with a behavioural
// multiplier on the mul_* lines and a result scoreboard.
// Define FP_MUL_SPECIAL_EN for both bench and RTL to exercise the bypass path.
`timescale 1ns/1ps
module tb_fp_mul_seq;
    import fp_mul_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          errors = 0;
    int          checks = 0;
    int          xfers = 0;
    int          results = 0;
    logic [35:0] sb[$];
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [31:0] m_res = '0;

    fp_mul_seq_if #(.DATA_W(32)) bus ();

    fp_mul_seq #(.DATA_W(32), .EXP_BIAS(127)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-precision multiply for normal operands (truncating).
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        logic [31:0] r;
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            e = e + 10'd1;
            r = {a[31] ^ b[31], e[7:0], p[46:24]};
        end else begin
            r = {a[31] ^ b[31], e[7:0], p[45:23]};
        end
        return r;
    endfunction

    // External multiplier: load clears and latches, enable alone computes.
    always @(posedge clk) begin
        if (bus.mul_load) begin
            m_a   <= bus.mul_a;
            m_b   <= bus.mul_b;
            m_res <= '0;
        end else if (bus.mul_en) begin
            m_res <= fmul(m_a, m_b);
        end
    end

    assign bus.mul_result = m_res;

    // Monitor: count transfers, pop and compare every delivered result.
    always @(negedge clk) begin
        logic [35:0] exp_v;
        if (!rst) begin
            if (bus.in_valid && bus.in_ready) xfers++;
            if (bus.out_valid && bus.out_ready) begin
                results++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %h flags %b, none outstanding",
                             bus.out_result, bus.out_flags);
                end else begin
                    exp_v = sb.pop_front();
                    if ({bus.out_result, bus.out_flags} !== exp_v) begin
                        errors++;
                        $display("FAIL result: got %h flags %b, required %h flags %b",
                                 bus.out_result, bus.out_flags, exp_v[35:4], exp_v[3:0]);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before the bench finished");
        $fatal(1);
    end

    task automatic do_xfer(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] flg, input bit keep);
        bit ok;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_valid = 1'b1;
        sb.push_back({res, flg});
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!keep) bus.in_valid = 1'b0;
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL accept: in_ready=0 for 40 cycles, required 1");
        end
    endtask

    task automatic run_one(input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic [3:0] flg, input int lat);
        logic [7:0] ld;
        logic [7:0] en;
        int         n;
        do_xfer(a, b, res, flg, 1'b0);
        ld = '0;
        en = '0;
        n  = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            ld[i-1] = bus.mul_load;
            en[i-1] = bus.mul_en;
            if (bus.out_valid) begin
                n = i;
                break;
            end
        end
        checks++;
        if (n != lat) begin
            errors++;
            $display("FAIL latency %h*%h: got %0d cycles, required %0d", a, b, n, lat);
        end
        checks++;
        if (ld !== ((lat == 4) ? 8'b0000_0001 : 8'b0)) begin
            errors++;
            $display("FAIL mul_load_pattern %h*%h: got %b, required %b", a, b, ld,
                     (lat == 4) ? 8'b0000_0001 : 8'b0);
        end
        checks++;
        if (en !== ((lat == 4) ? 8'b0000_0011 : 8'b0)) begin
            errors++;
            $display("FAIL mul_en_pattern %h*%h: got %b, required %b", a, b, en,
                     (lat == 4) ? 8'b0000_0011 : 8'b0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'hDEAD_BEEF;
        bus.in_b      = 32'h1234_5678;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
        checks++; if (bus.out_result !== 32'h0) begin errors++; $display("FAIL rst_out_result: got %h, required 0", bus.out_result); end
        checks++; if (bus.out_flags !== 4'h0) begin errors++; $display("FAIL rst_out_flags: got %b, required 0", bus.out_flags); end
        checks++; if (bus.mul_a !== 32'h0 || bus.mul_b !== 32'h0) begin errors++; $display("FAIL rst_mul_ab: got %h %h, required 0 0", bus.mul_a, bus.mul_b); end
        checks++; if (bus.mul_load !== 1'b0 || bus.mul_en !== 1'b0) begin errors++; $display("FAIL rst_mul_ctl: got load=%b en=%b, required 0 0", bus.mul_load, bus.mul_en); end
        bus.in_valid = 1'b0;
        rst          = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_normal();
        bus.out_ready = 1'b1;
        run_one(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0, 4);
        run_one(32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 4'h0, 4);
        run_one(32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'h0, 4);
        run_one(32'h4080_0000, 32'h4080_0000, 32'h4180_0000, 4'h0, 4);
        run_one(32'h3F00_0000, 32'h4000_0000, 32'h3F80_0000, 4'h0, 4);
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        run_one(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0, 4);
        for (int i = 0; i < 6; i++) begin
            bus.in_a     = $urandom;
            bus.in_b     = $urandom;
            bus.in_valid = (i % 2) == 0;
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cycle %0d: got %b, required 1", i, bus.out_valid); end
            checks++; if (bus.out_result !== 32'h40C0_0000) begin errors++; $display("FAIL bp_out_result cycle %0d: got %h, required 40c00000", i, bus.out_result); end
            checks++; if (bus.in_ready !== 1'b0 || bus.mul_a !== 32'h4000_0000) begin errors++; $display("FAIL bp_in_ready_mul_a cycle %0d: got %b %h, required 0 40000000", i, bus.in_ready, bus.mul_a); end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_idle_return: got in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midop();
        bit seen;
        bus.out_ready = 1'b1;
        do_xfer(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'h0, 1'b0);
        @(posedge clk);
        #1;
        checks++;
        if (bus.mul_load !== 1'b0 || bus.mul_en !== 1'b1) begin
            errors++;
            $display("FAIL midop_in_calc: got load=%b en=%b, required 0 1", bus.mul_load, bus.mul_en);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_back());
        checks++;
        if (bus.mul_en !== 1'b0 || bus.mul_a !== 32'h0 || bus.out_result !== 32'h0) begin
            errors++;
            $display("FAIL midop_after_rst: got en=%b mul_a=%h out_result=%h, required 0 0 0",
                     bus.mul_en, bus.mul_a, bus.out_result);
        end
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midop_no_out_valid: got out_valid=1, required 0");
        end
        @(posedge clk);
        #1;
        run_one(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'h0, 4);
    endtask

`ifdef FP_MUL_SPECIAL_EN
    task automatic test_special();
        bus.out_ready = 1'b1;
        run_one(32'h0000_0000, 32'hC000_0000, 32'h8000_0000, 4'b0011, 1);
        run_one(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1001, 1);
        run_one(32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000, 4'b0101, 1);
        run_one(32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0000, 4'b1001, 1);
        run_one(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 4);
    endtask
`else
    task automatic test_no_special();
        bus.out_ready = 1'b1;
        run_one(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 4'h0, 4);
    endtask
`endif

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic [31:0] vr [4];
        int          bx;
        int          br;
        va = '{32'h4000_0000, 32'h3FC0_0000, 32'h4080_0000, 32'hC000_0000};
        vb = '{32'h4040_0000, 32'h3FC0_0000, 32'h4080_0000, 32'h4040_0000};
        vr = '{32'h40C0_0000, 32'h4010_0000, 32'h4180_0000, 32'hC0C0_0000};
        bx = xfers;
        br = results;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_xfer(va[i], vb[i], vr[i], 4'h0, i < 3);
        end
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got %0d outstanding, required 0", sb.size());
        end
        checks++;
        if (xfers - bx != 4) begin
            errors++;
            $display("FAIL b2b_transfers: got %0d, required 4", xfers - bx);
        end
        checks++;
        if (results - br != 4) begin
            errors++;
            $display("FAIL b2b_results: got %0d, required 4", results - br);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_normal();
        test_backpressure();
        test_reset_midop();
`ifdef FP_MUL_SPECIAL_EN
        test_special();
`else
        test_no_special();
`endif
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 Parameter DATA_W, default 32, operand/result width; only 32 (IEEE-754 single) SHALL be supported.
REQ-002 Parameter EXP_BIAS, default 127, exponent bias used by the special-case path.
REQ-003 Port clk, input, 1, single clock; all logic SHALL be on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset.
REQ-005 Port in_valid, input, 1, request holds a valid operand pair.
REQ-006 Port in_ready, output, 1, sequencer can accept a request.
REQ-007 Port in_a, input, DATA_W, operand A.
REQ-008 Port in_b, input, DATA_W, operand B.
REQ-009 Port out_valid, output, 1, out_result and out_flags are valid.
REQ-010 Port out_ready, input, 1, consumer accepts the result.
REQ-011 Port out_result, output, DATA_W, product.
REQ-012 Port out_flags, output, 4, {nan, inf, zero, bypass}.
REQ-013 Port mul_load, output, 1, drives the multiplier load input.
REQ-014 Port mul_en, output, 1, drives the multiplier en input.
REQ-015 Port mul_a / mul_b, output, DATA_W each, registered operands to the multiplier A/B.
REQ-016 Port mul_result, input, DATA_W, multiplier result.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, CALC, CAPT, HOLD.
REQ-018 in_ready SHALL be 1 only in IDLE; a transfer occurs on an edge where in_valid and in_ready are both 1.
REQ-019 On transfer, in_a/in_b SHALL be latched into mul_a/mul_b and the state SHALL go to LOAD.
REQ-020 LOAD: mul_load=1, mul_en=1; next state CALC.
REQ-021 CALC: mul_load=0, mul_en=1; next state CAPT.
REQ-022 CAPT: mul_load=0, mul_en=0; mul_result SHALL be registered into out_result and out_flags cleared; next state HOLD.
REQ-023 mul_load and mul_en SHALL be 0 in IDLE and HOLD and SHALL be decoded from the state register.
REQ-024 HOLD: out_valid=1; out_result and out_flags SHALL stay stable until out_ready=1, then next state IDLE.
REQ-025 Normal latency SHALL be 4 cycles from the transfer edge to the first cycle of out_valid=1; throughput is one request per at least 5 cycles.
REQ-026 in_a/in_b changes outside a transfer edge SHALL have no effect.
REQ-027 out_ready while out_valid=0 SHALL be ignored.
REQ-028 A new request SHALL NOT be accepted in the cycle HOLD exits (in_ready=0 in HOLD).

Reset
REQ-029 rst=1 at an edge SHALL force IDLE, out_valid=0, out_result=0, out_flags=0, mul_a=0, mul_b=0, taking priority over every other event.
REQ-030 Reset in any state SHALL abandon the operation; no out_valid SHALL follow for it; mul_en=0 from the cycle after the reset edge.

Configuration
REQ-031 With macro FP_MUL_SPECIAL_EN defined, operands SHALL be classified at transfer. If either operand is NaN, or is inf times zero, the result is 32'h7FC00000 with flags 4'b1001. Otherwise, if either operand is inf, the result is {sA^sB, 8'hFF, 23'h0} with flags 4'b0101. Otherwise, if either exponent is 0, the result is {sA^sB, 31'h0} with flags 4'b0011. These cases SHALL go IDLE->HOLD directly (out_valid 1 cycle after transfer) with mul_load/mul_en never asserted.
REQ-032 Without FP_MUL_SPECIAL_EN, every request SHALL take the LOAD/CALC/CAPT path and out_flags SHALL be tied to 0.

Structure
REQ-033 Shared package fp_mul_pkg SHALL hold the state enum, the sign/exponent/mantissa field widths and positions, EXP_BIAS default, the QNAN constant 32'h7FC00000 and the flag bit indices.
REQ-034 Combinational sub-module fp_classify (operand -> is_zero, is_inf, is_nan, sign) SHALL be instantiated twice, only under FP_MUL_SPECIAL_EN.

Verification
REQ-035 Normal product: in_a=32'h40000000, in_b=32'h40400000, out_ready=1 -> mul_load=1 for one cycle, then mul_en-only for one cycle; out_result=32'h40C00000 and out_flags=0, out_valid 4 cycles after the transfer edge.
REQ-036 Backpressure: same request with out_ready=0 for 6 cycles -> out_valid stays 1 and out_result stays 32'h40C00000, and in_ready stays 0; IDLE is re-entered one cycle after out_ready=1.
REQ-037 Reset mid-op: rst pulse while in CALC -> out_valid never rises for that request; the next request 32'h3F800000*32'h3F800000 -> 32'h3F800000.
REQ-038 Special (macro on): 32'h00000000*32'hC0000000 -> 32'h80000000 with flags 4'b0011. 32'h7F800000*32'h00000000 -> 32'h7FC00000 with flags 4'b1001, out_valid 1 cycle after transfer, mul_en never 1.
REQ-039 Macro off: 32'h7F800000*32'h3F800000 goes through the multiplier path with 4-cycle latency and out_flags=0.
REQ-040 Handshake: in_valid held high across back-to-back requests -> exactly one transfer per IDLE visit, and every accepted request yields exactly one result.
